// File: rtl/duc_tx_pkg.sv
// rtl/duc_tx_pkg.sv - shared widths, FSM encodings, NCO sign table and DAC saturation for duc_tx
package duc_tx_pkg;

    localparam int BB_W  = 18;
    localparam int DAC_W = 16;
    localparam int MIX_W = BB_W + 1;
    localparam int RND_W = MIX_W + 1;

    localparam logic signed [RND_W-1:0] SAT_HI = RND_W'(32767);
    localparam logic signed [RND_W-1:0] SAT_LO = RND_W'(-32768);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic use_q;
        logic neg;
    } nco_sel_t;

    // fs/4 carrier: cos/sin are only 0/+-1, so mixing reduces to a select and a negate
    function automatic nco_sel_t nco_sel(input logic [1:0] phase);
        case (phase)
            2'd0:    return '{use_q: 1'b0, neg: 1'b0};
            2'd1:    return '{use_q: 1'b1, neg: 1'b1};
            2'd2:    return '{use_q: 1'b0, neg: 1'b1};
            default: return '{use_q: 1'b1, neg: 1'b0};
        endcase
    endfunction

    function automatic logic signed [DAC_W-1:0] sat_dac(input logic signed [RND_W-1:0] r);
        if (r > SAT_HI) return DAC_W'(SAT_HI);
        if (r < SAT_LO) return DAC_W'(SAT_LO);
        return DAC_W'(r);
    endfunction

endpackage

// File: rtl/duc_fifo.sv
// rtl/duc_fifo.sv - synchronous {I,Q} sample FIFO with registered count and no push-to-pop bypass
module duc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q != FULL);
    assign do_pop  = pop_i && (cnt_q != '0);
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push && rst_n && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/duc_tx.sv
// rtl/duc_tx.sv - single-channel DUC: FIFO, linear interpolation, fs/4 mixing, round/saturate to DAC
module duc_tx
    import duc_tx_pkg::*;
#(
    parameter int INTERP_LOG2 = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    PRI,
    input  logic                    enable,
    input  logic signed [BB_W-1:0]  din_I,
    input  logic signed [BB_W-1:0]  din_Q,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic signed [DAC_W-1:0] dac_data,
    output logic                    dac_valid,
    output logic                    underflow,
    output logic [1:0]              state
);
    localparam int CW  = $clog2(FIFO_DEPTH);
    localparam int P_W = BB_W + 1 + INTERP_LOG2;
    localparam logic [INTERP_LOG2-1:0] K_LAST = '1;
    localparam logic [CW:0] FULL = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW:0] TWO  = (CW+1)'(2);

    state_e                  state_q;
    logic                    pri_q, prime_q, underflow_q;
    logic [INTERP_LOG2-1:0]  k_q;
    logic [1:0]              phase_q;
    logic signed [BB_W-1:0]  x0i_q, x0q_q, x1i_q, x1q_q;

    logic                    pri_rise, push, pop, flush;
    logic [CW:0]             fifo_count;
    logic [2*BB_W-1:0]       fifo_rdata;
    logic signed [BB_W-1:0]  rd_i, rd_q;

    assign pri_rise  = PRI && !pri_q;
    assign din_ready = (state_q != ST_IDLE) && (fifo_count < FULL);
    assign push      = din_valid && din_ready;
    assign flush     = (state_q == ST_IDLE);
    assign rd_i      = fifo_rdata[2*BB_W-1:BB_W];
    assign rd_q      = fifo_rdata[BB_W-1:0];

    // pop must mirror exactly when the FSM below consumes a sample
    always_comb begin
        pop = 1'b0;
        if (enable) begin
            case (state_q)
                ST_PRIME: pop = prime_q || (fifo_count >= TWO);
                ST_RUN:   pop = !pri_rise && (k_q == K_LAST) && (fifo_count != '0);
                default:  pop = 1'b0;
            endcase
        end
    end

    duc_fifo #(.DEPTH(FIFO_DEPTH), .W(2*BB_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i ({din_I, din_Q}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pri_q       <= 1'b0;
            prime_q     <= 1'b0;
            underflow_q <= 1'b0;
            k_q         <= '0;
            phase_q     <= '0;
            x0i_q       <= '0;
            x0q_q       <= '0;
            x1i_q       <= '0;
            x1q_q       <= '0;
        end else begin
            pri_q <= PRI;
            if (!enable) begin
                state_q <= ST_IDLE;
                prime_q <= 1'b0;
                k_q     <= '0;
                phase_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pri_rise) begin
                            state_q <= ST_PRIME;
                            prime_q <= 1'b0;
                        end
                    end
                    ST_PRIME: begin
                        if (pri_rise) underflow_q <= 1'b0;
                        if (prime_q) begin
                            x1i_q   <= rd_i;
                            x1q_q   <= rd_q;
                            prime_q <= 1'b0;
                            state_q <= ST_RUN;
                            k_q     <= '0;
                            phase_q <= '0;
                        end else if (fifo_count >= TWO) begin
                            x0i_q   <= rd_i;
                            x0q_q   <= rd_q;
                            prime_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (pri_rise) begin
                            state_q     <= ST_PRIME;
                            prime_q     <= 1'b0;
                            k_q         <= '0;
                            phase_q     <= '0;
                            underflow_q <= 1'b0;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            phase_q <= phase_q + 2'd1;
                            if (k_q == K_LAST) begin
                                x0i_q <= x1i_q;
                                x0q_q <= x1q_q;
                                // an empty FIFO flattens the output rather than stalling the DAC
                                if (fifo_count != '0) begin
                                    x1i_q <= rd_i;
                                    x1q_q <= rd_q;
                                end else begin
                                    underflow_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    logic signed [P_W-1:0]   kx, di, dq, pi, pq, si, sq;
    logic signed [BB_W-1:0]  yi_q, yq_q;
    logic [1:0]              ph1_q;
    logic                    v1_q, v2_q, v3_q;
    nco_sel_t                sel;
    logic signed [BB_W-1:0]  mix_src;
    logic signed [MIX_W-1:0] m_d, m_q;
    logic signed [RND_W-1:0] rnd_sum, rnd;
    logic signed [DAC_W-1:0] dac_q;

    assign kx = P_W'({1'b0, k_q});
    assign di = P_W'(x1i_q) - P_W'(x0i_q);
    assign dq = P_W'(x1q_q) - P_W'(x0q_q);
    assign pi = di * kx;
    assign pq = dq * kx;
    assign si = P_W'(x0i_q) + (pi >>> INTERP_LOG2);
    assign sq = P_W'(x0q_q) + (pq >>> INTERP_LOG2);

    assign sel     = nco_sel(ph1_q);
    assign mix_src = sel.use_q ? yq_q : yi_q;
    assign m_d     = sel.neg ? -MIX_W'(mix_src) : MIX_W'(mix_src);
    assign rnd_sum = RND_W'(m_q) + RND_W'(2);
    assign rnd     = rnd_sum >>> 2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yi_q  <= '0;
            yq_q  <= '0;
            ph1_q <= '0;
            m_q   <= '0;
            dac_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else begin
            yi_q  <= BB_W'(si);
            yq_q  <= BB_W'(sq);
            ph1_q <= phase_q;
            v1_q  <= (state_q == ST_RUN);
            m_q   <= m_d;
            v2_q  <= v1_q;
            dac_q <= v2_q ? sat_dac(rnd) : '0;
            v3_q  <= v2_q;
        end
    end

    assign dac_data  = dac_q;
    assign dac_valid = v3_q;
    assign underflow = underflow_q;
    assign state     = state_q;

endmodule

// File: tb/tb_duc_tx.sv
// tb/tb_duc_tx.sv - self-checking bench for duc_tx against an arithmetic reference model
module tb_duc_tx;

    logic               clk = 1'b0;
    logic               rst_n, PRI, enable, din_valid;
    logic signed [17:0] din_I, din_Q;
    logic               din_ready, dac_valid, underflow;
    logic signed [15:0] dac_data;
    logic [1:0]         state;

    always #5 clk = ~clk;

    duc_tx #(.INTERP_LOG2(2), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PRI       (PRI),
        .enable    (enable),
        .din_I     (din_I),
        .din_Q     (din_Q),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .underflow (underflow),
        .state     (state)
    );

    typedef struct { int i; int q; } samp_t;
    samp_t src[$];
    int    head;
    bit    acc;
    int    got[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    lat;
    bit    seen_block;
    int    ca, cb;

    function automatic int fdiv4(int a);
        return (a - (((a % 4) + 4) % 4)) / 4;
    endfunction

    function automatic int sat16(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // expected DAC word n after RUN entry; samples past the end repeat the last one
    function automatic int model_out(int n);
        int j, k, last, a, b, yi, yq, m;
        j = n / 4;
        k = n % 4;
        last = src.size() - 1;
        a = (j < last) ? j : last;
        b = (j + 1 < last) ? j + 1 : last;
        yi = src[a].i + fdiv4((src[b].i - src[a].i) * k);
        yq = src[a].q + fdiv4((src[b].q - src[a].q) * k);
        case (n % 4)
            0:       m = yi;
            1:       m = -yq;
            2:       m = -yi;
            default: m = yq;
        endcase
        return sat16(fdiv4(m + 2));
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        acc = ((din_valid && din_ready && rst_n) === 1'b1);
        @(negedge clk);
        if (acc) head++;
        if (head < src.size()) begin
            din_valid = 1'b1;
            din_I     = 18'(src[head].i);
            din_Q     = 18'(src[head].q);
        end else begin
            din_valid = 1'b0;
            din_I     = '0;
            din_Q     = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; PRI = 1'b0;
        src.delete(); got.delete(); head = 0;
        din_valid = 1'b0; din_I = '0; din_Q = '0;
        repeat (5) cyc();
    endtask

    task automatic fill_const(int len, int vi, int vq);
        for (int n = 0; n < len; n++) src.push_back('{vi, vq});
    endtask

    task automatic pulse_pri();
        PRI = 1'b1;
        cyc();
        PRI = 1'b0;
    endtask

    task automatic wait_valid(output int cycles, input int limit);
        cycles = 0;
        while (dac_valid !== 1'b1 && cycles < limit) begin
            cyc();
            cycles++;
        end
        chk("valid_timeout", 32'(dac_valid), 1);
    endtask

    task automatic start_run(input string tag);
        rst_n = 1'b1; enable = 1'b1;
        cyc();
        pulse_pri();
        wait_valid(lat, 40);
        chk({tag, "_latency"}, lat, 7);
    endtask

    task automatic capture(input string tag, input int nout);
        for (int n = 0; n < nout; n++) begin
            chk($sformatf("%s[%0d]", tag, n), 32'(dac_data), model_out(n));
            got.push_back(int'(dac_data));
            if (din_valid && !din_ready) seen_block = 1'b1;
            cyc();
        end
        chk({tag, "_valid_held"}, 32'(dac_valid), 1);
    endtask

    task automatic chk4(input string tag, int e0, int e1, int e2, int e3);
        chk({tag, "_lit0"}, got[0], e0);
        chk({tag, "_lit1"}, got[1], e1);
        chk({tag, "_lit2"}, got[2], e2);
        chk({tag, "_lit3"}, got[3], e3);
    endtask

    initial begin
        do_reset();
        chk("rst_dac_data", 32'(dac_data), 0);
        chk("rst_dac_valid", 32'(dac_valid), 0);
        chk("rst_din_ready", 32'(din_ready), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_state", 32'(state), 0);

        // constant tone
        fill_const(40, 4000, 0);
        start_run("tone");
        capture("tone", 16);
        chk4("tone", 1000, 0, -1000, 0);
        chk("tone_underflow", 32'(underflow), 0);

        // interpolation ramp
        do_reset();
        src.push_back('{0, 0});
        fill_const(40, 400, 0);
        start_run("ramp");
        capture("ramp", 12);
        chk4("ramp", 0, 0, -50, 0);

        // saturation on I and Q
        do_reset();
        fill_const(40, -131072, 0);
        start_run("satI");
        capture("satI", 8);
        chk4("satI", -32768, 0, 32767, 0);

        do_reset();
        fill_const(40, 0, 131071);
        start_run("satQ");
        capture("satQ", 8);
        chk4("satQ", 0, -32768, 0, 32767);

        // random stream with backpressure, then mid-run reset
        do_reset();
        for (int n = 0; n < 30; n++)
            src.push_back('{int'($urandom_range(0, 262143)) - 131072,
                           int'($urandom_range(0, 262143)) - 131072});
        start_run("rand");
        seen_block = 1'b0;
        capture("rand", 80);
        chk("rand_backpressure", 32'(seen_block), 1);
        chk("rand_underflow", 32'(underflow), 0);
        rst_n = 1'b0;
        cyc();
        chk("midrst_valid", 32'(dac_valid), 0);
        chk("midrst_data", 32'(dac_data), 0);
        chk("midrst_state", 32'(state), 0);
        chk("midrst_ready", 32'(din_ready), 0);

        // underflow: short burst, output flattens, PRI clears the flag
        do_reset();
        for (int n = 0; n < 6; n++)
            src.push_back('{int'($urandom_range(0, 262143)) - 131072,
                           int'($urandom_range(0, 262143)) - 131072});
        start_run("uf");
        chk("uf_early", 32'(underflow), 0);
        capture("uf", 40);
        chk("uf_set", 32'(underflow), 1);
        pulse_pri();
        chk("uf_cleared", 32'(underflow), 0);
        chk("uf_prime", 32'(state), 1);
        repeat (10) cyc();
        chk("uf_waiting", 32'(state), 1);
        chk("uf_valid_low", 32'(dac_valid), 0);

        // PRI mid-RUN restarts the carrier at +I
        do_reset();
        ca = int'($urandom_range(0, 262143)) - 131072;
        cb = int'($urandom_range(0, 262143)) - 131072;
        fill_const(200, ca, cb);
        start_run("pri");
        capture("pri_pre", 10);
        pulse_pri();
        lat = 0;
        while (dac_valid === 1'b1 && lat < 10) begin
            cyc();
            lat++;
        end
        chk("pri_gap_start", lat, 3);
        wait_valid(lat, 20);
        chk("pri_restart_latency", lat, 2);
        got.delete();
        capture("pri_post", 8);
        chk("pri_first_is_plusI", got[0], sat16(fdiv4(ca + 2)));

        // enable=0 mid-RUN: IDLE next cycle, valid tail of 3, FIFO flushed
        enable = 1'b0;
        cyc();
        chk("dis_state", 32'(state), 0);
        chk("dis_ready", 32'(din_ready), 0);
        cyc();
        cyc();
        chk("dis_valid_tail", 32'(dac_valid), 1);
        cyc();
        chk("dis_valid_low", 32'(dac_valid), 0);
        chk("dis_data_zero", 32'(dac_data), 0);
        src.delete();
        head = 0;
        enable = 1'b1;
        cyc();
        pulse_pri();
        repeat (12) cyc();
        chk("flush_state_prime", 32'(state), 1);
        chk("flush_valid_low", 32'(dac_valid), 0);
        chk("flush_ready", 32'(din_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/duc_tx.md
Name: duc_tx

Overview:
- Single-channel digital up-converter: the transmit-direction counterpart of the receive DDC chain.
- Accepts 18-bit baseband I/Q samples at clk/2^INTERP_LOG2 through a valid/ready handshake and buffers them in a small FIFO.
- Linearly interpolates to the full clk rate, mixes to fs/4 IF with a multiplier-free quarter-rate NCO, and rounds/saturates to 16-bit DAC words.
- PRI-aligned: NCO phase and interpolation counter restart on PRI so transmit timing is repeatable per pulse.

Parameters:
- INTERP_LOG2, 2, log2 of interpolation factor (INTERP = 4; 25 MHz baseband to 100 MHz).
- FIFO_DEPTH, 4, input sample FIFO depth (power of 2, ≥ 2).

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset, synchronous, active-low
- PRI  in  1  pulse repetition strobe; rising edge detected internally
- enable  in  1  transmit enable
- din_I  in  18  baseband I, signed
- din_Q  in  18  baseband Q, signed
- din_valid  in  1  input sample valid
- din_ready  out  1  FIFO can accept a sample
- dac_data  out  16  IF sample to DAC, signed
- dac_valid  out  1  dac_data valid
- underflow  out  1  sticky: FIFO was empty when a sample was needed
- state  out  2  FSM state, for debug

Behaviour:
- Reset (rst_n=0 at clk edge): dac_data=0, dac_valid=0, din_ready=0, underflow=0, state=IDLE, FIFO empty, x0=x1=0, k=0, phase=0, pipeline cleared.
- Push: din_valid & din_ready; registered push/pop; no same-cycle bypass, so a pop on an empty FIFO counts as empty even if a push occurs that cycle.
- din_ready = (state != IDLE) & (count < FIFO_DEPTH), computed from the registered count.
- States (encodings): IDLE=0, PRIME=1, RUN=2.
- IDLE:
  - FIFO held flushed; dac_valid=0; dac_data=0.
  - PRI rising edge with enable=1 goes to PRIME.
- PRIME:
  - Wait until count ≥ 2, then pop two samples into x0, x1 (one per cycle, two cycles).
  - Go to RUN with k=0, phase=0.
- RUN:
  - k increments each cycle, modulo INTERP.
  - When k==INTERP-1: x0 <= x1 and x1 <= pop.
  - If the FIFO is empty at that point: underflow <= 1, x0 <= x1, and x1 is held (output flattens; no stall).
- PRI rising edge in RUN: go to PRIME; FIFO kept; k and phase reset; underflow cleared.
- PRI edge in PRIME: underflow cleared; no other effect.
- enable=0 in any state: IDLE next cycle. Priority is reset > enable=0 > PRI.
- Interpolation, stage 1 (registered):
  - d = x1 - x0 (19b signed).
  - p = d*k ((19+INTERP_LOG2)b).
  - y = x0 + (p >>> INTERP_LOG2), arithmetic shift (floor); 18b.
- Mixing, stage 2, by phase:
  - phase 0: m=+yI
  - phase 1: m=-yQ
  - phase 2: m=-yI
  - phase 3: m=+yQ
  - m is 19b signed (covers -(-131072)).
  - phase is a 2-bit counter running with k.
- Output, stage 3:
  - r = (m + 2) >>> 2.
  - Saturate to [-32768, 32767] into dac_data.
- Latency:
  - dac_valid = 3-cycle delayed (state==RUN).
  - First valid dac_data appears 3 cycles after RUN entry; continuous every clk while RUN.
- On leaving RUN, dac_valid drops after the same 3-cycle delay. dac_data is forced to 0 whenever dac_valid=0.
- Mid-operation reset: all state returns to reset values at the next edge; no partial output.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE/PRIME/RUN)
  - NCO phase sign table
  - DAC width 16 and baseband width 18
  - saturation limits
- One sub-module: duc_fifo (synchronous FIFO of 36-bit {I,Q}; push/pop/count/flush; registered count; no bypass).

Test Plan:
- Reset: hold rst_n=0 for 5 cycles → dac_data=0, dac_valid=0, din_ready=0, underflow=0, state=0.
- Constant tone:
  - Stimulus: enable=1, PRI pulse, then I=4000, Q=0 streamed continuously.
  - Response: after RUN + 3 cycles, dac_data repeats 1000, 0, -1000, 0; dac_valid stays high.
- Interpolation ramp:
  - Stimulus: samples I=0, then 400, then 400 …, Q=0.
  - Response: first output period y = 0, 100, 200, 300; dac_data = 0, 0, -50, 0.
- Saturation:
  - I=-131072, Q=0 → dac_data -32768 at phase 0, 32767 at phase 2.
  - Q=131071, I=0 → phase 1 gives -32768 (-131071+2 >>> 2 = -32768), phase 3 gives 32767.
- Underflow and backpressure:
  - Burst 6 samples with no pops in PRIME-blocked condition → din_ready low once count=4.
  - After RUN starts, stop input → underflow=1 at the first k==3 with empty FIFO; dac_data holds the flattened tone.
  - Next PRI clears underflow.
- Control events:
  - enable=0 mid-RUN → state=IDLE next cycle; dac_valid low 3 cycles later; FIFO flushed; din_ready=0.
  - PRI mid-RUN → phase restarts at 0, so the output sequence restarts at +I.
